branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-003 SHALL have port ex_valid, input, 1, EX0 holds a valid instruction.
REQ-004 SHALL have port ex_stall, input, 1, EX0 instruction held this cycle, not leaving.
REQ-005 SHALL have port ex_pc, input, 32, instruction PC.
REQ-006 SHALL have port ex_btype, input, 2: 00 not branch, 01 unconditional direct, 10 PC-relative conditional, 11 indirect.
REQ-007 SHALL have port ex_cond_op, input, 4: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 b, 7 bl, 8 jirl; 9-15 treated as not taken.
REQ-008 SHALL have ports ex_src1 and ex_src2, input, 32 each, resolved operands.
REQ-009 SHALL have port ex_offs, input, 32, sign-extended byte offset.
REQ-010 SHALL have ports ex_pred_taken (input, 2) and ex_pred_pc (input, 32), the predictor output carried down the pipe with the instruction.
REQ-011 SHALL have outputs fact_pc (32), fact_tpc (32), fact_taken (1), predict_dir_fail (1), predict_add_fail (1), predictor update bus.
REQ-012 SHALL have outputs redirect_valid (1) and redirect_pc (32), front-end flush request.
REQ-013 SHALL have outputs br_cnt (32) and miss_cnt (32), statistics.

Function
REQ-014 SHALL accept an instruction when ex_valid && !ex_stall && state permits; only then is it evaluated, so each instruction is evaluated once.
REQ-015 SHALL compute actual_taken: ops 0-5 by compare (signed for 2/3, unsigned for 4/5); ops 6-8 always 1.
REQ-016 SHALL compute actual_tpc = ex_src1+ex_offs for op 8, ex_pc+ex_offs otherwise, mod 2^32.
REQ-017 SHALL treat btype 00 as actual_taken=0 regardless of ex_cond_op.
REQ-018 SHALL define pred_t = (ex_pred_taken != 00).
REQ-019 SHALL set dir_fail = pred_t != actual_taken.
REQ-020 SHALL set add_fail = pred_t && actual_taken && (ex_pred_pc != actual_tpc).
REQ-021 SHALL register all outputs: an instruction accepted in cycle N drives them in cycle N+1 for exactly one cycle.
REQ-022 SHALL, on an accepted cycle, load fact_pc=ex_pc, fact_tpc=actual_tpc, fact_taken=actual_taken, and drive predict_dir_fail and predict_add_fail.
REQ-023 SHALL drive fact_taken, predict_dir_fail, predict_add_fail and redirect_valid to 0 in non-accepted cycles; fact_pc and fact_tpc hold their last value.
REQ-024 SHALL pulse redirect_valid when dir_fail||add_fail; redirect_pc = actual_taken ? actual_tpc : ex_pc+4.
REQ-025 SHALL, for a non-branch predicted taken (alias), drive dir_fail=1, fact_taken=0 and redirect to ex_pc+4.
REQ-026 SHALL implement a two-state FSM, RUN and SHADOW; registered target_q holds the last redirect_pc.
REQ-027 SHALL move RUN->SHADOW on the same edge that asserts redirect_valid.
REQ-028 SHALL, in SHADOW, ignore ex_valid instructions with ex_pc != target_q: no update, no counting.
REQ-029 SHALL, in SHADOW, on ex_valid && ex_pc == target_q && !ex_stall, accept that instruction normally in the same cycle and return to RUN, or to SHADOW with a new target if that instruction also mispredicts.
REQ-030 SHALL increment br_cnt per accepted instruction with btype != 00 and miss_cnt per redirect; both wrap at 2^32.

Reset
REQ-031 SHALL, with rstn low at an edge, set state RUN, target_q=0, all outputs and counters 0.
REQ-032 SHALL let reset override any pending evaluation or SHADOW state; no redirect is issued on the cycle after reset.

Verification
REQ-033 SHALL cover: beq pc=0x1c000100, src1=src2=5, offs=0x40, pred_taken=01, pred_pc=0x1c000140 -> next cycle fact_taken=1, fact_tpc=0x1c000140, no fail, no redirect, br_cnt=1.
REQ-034 SHALL cover: bne equal operands at pc=0x1c000200, pred_taken=10 -> dir_fail=1, fact_taken=0, redirect_pc=0x1c000204, miss_cnt=1, state SHADOW.
REQ-035 SHALL cover: jirl src1=0x1c008000, offs=8, pred_pc=0x1c000300, pred_taken=11 -> add_fail=1, dir_fail=0, redirect_pc=0x1c008008.
REQ-036 SHALL cover: after a redirect to 0x1c000204, ex_pc=0x1c000208 then 0x1c000204 -> first ignored (fact_taken=0, counters unchanged), second accepted, state RUN.
REQ-037 SHALL cover: ex_stall=1 for 3 cycles on a taken b -> exactly one fact_taken pulse, after stall drops.
REQ-038 SHALL cover: rstn low while in SHADOW -> all outputs 0, state RUN, counters 0 the next cycle.

Source files
------------

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch resolution, predictor update bus and wrong-path shadow FSM
//
// Purpose: evaluates the EX0 branch once when it leaves the stage, compares the
// actual direction/target with the carried prediction, and reports one registered
// cycle of predictor update plus a front-end redirect on a mispredict. After a
// redirect, wrong-path instructions are ignored until the redirect target arrives.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   ex_valid, ex_stall           EX0 holds an instruction / instruction held this cycle
//   ex_pc, ex_btype, ex_cond_op  instruction PC, branch class, condition opcode
//   ex_src1, ex_src2, ex_offs    resolved operands and sign-extended byte offset
//   ex_pred_taken, ex_pred_pc    predictor output carried with the instruction
//   fact_pc, fact_tpc, fact_taken, predict_dir_fail, predict_add_fail
//                                predictor update bus (one-cycle pulse per evaluation)
//   redirect_valid, redirect_pc  front-end flush request
//   br_cnt, miss_cnt             branch and redirect statistics (wrap at 2^32)
module branch_resolve (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  ex_btype,
  input  logic [3:0]  ex_cond_op,
  input  logic [31:0] ex_src1,
  input  logic [31:0] ex_src2,
  input  logic [31:0] ex_offs,
  input  logic [1:0]  ex_pred_taken,
  input  logic [31:0] ex_pred_pc,
  output logic [31:0] fact_pc,
  output logic [31:0] fact_tpc,
  output logic        fact_taken,
  output logic        predict_dir_fail,
  output logic        predict_add_fail,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  typedef enum logic {RUN, SHADOW} state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;

  logic        accept;
  logic        cond_taken;
  logic        actual_taken;
  logic [31:0] actual_tpc;
  logic        pred_t;
  logic        dir_fail;
  logic        add_fail;
  logic        mispredict;
  logic [31:0] fix_pc;

  always_comb begin
    cond_taken   = 1'b0;
    actual_taken = 1'b0;
    actual_tpc   = 32'd0;
    pred_t       = 1'b0;
    dir_fail     = 1'b0;
    add_fail     = 1'b0;
    mispredict   = 1'b0;
    fix_pc       = 32'd0;
    accept       = 1'b0;
    state_d      = state_q;
    target_d     = target_q;

    case (ex_cond_op)
      4'd0:    cond_taken = (ex_src1 == ex_src2);
      4'd1:    cond_taken = (ex_src1 != ex_src2);
      4'd2:    cond_taken = ($signed(ex_src1) <  $signed(ex_src2));
      4'd3:    cond_taken = ($signed(ex_src1) >= $signed(ex_src2));
      4'd4:    cond_taken = (ex_src1 <  ex_src2);
      4'd5:    cond_taken = (ex_src1 >= ex_src2);
      4'd6,
      4'd7,
      4'd8:    cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase

    // A non-branch never takes, whatever opcode field it happens to carry.
    actual_taken = (ex_btype != 2'b00) && cond_taken;
    actual_tpc   = (ex_cond_op == 4'd8) ? (ex_src1 + ex_offs) : (ex_pc + ex_offs);
    pred_t       = (ex_pred_taken != 2'b00);
    dir_fail     = (pred_t != actual_taken);
    add_fail     = pred_t && actual_taken && (ex_pred_pc != actual_tpc);
    mispredict   = dir_fail || add_fail;
    fix_pc       = actual_taken ? actual_tpc : (ex_pc + 32'd4);

    // In SHADOW only the redirect target itself may leave EX0 as a real instruction.
    accept = ex_valid && !ex_stall && ((state_q == RUN) || (ex_pc == target_q));

    if (accept) begin
      if (mispredict) begin
        state_d  = SHADOW;
        target_d = fix_pc;
      end else begin
        state_d  = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= RUN;
      target_q         <= 32'd0;
      fact_pc          <= 32'd0;
      fact_tpc         <= 32'd0;
      fact_taken       <= 1'b0;
      predict_dir_fail <= 1'b0;
      predict_add_fail <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'd0;
      br_cnt           <= 32'd0;
      miss_cnt         <= 32'd0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      fact_taken       <= accept && actual_taken;
      predict_dir_fail <= accept && dir_fail;
      predict_add_fail <= accept && add_fail;
      redirect_valid   <= accept && mispredict;
      if (accept) begin
        fact_pc  <= ex_pc;
        fact_tpc <= actual_tpc;
        if (ex_btype != 2'b00) br_cnt <= br_cnt + 32'd1;
      end
      if (accept && mispredict) begin
        redirect_pc <= fix_pc;
        miss_cnt    <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed vector bench for branch_resolve
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [1:0]  ex_btype;
  logic [3:0]  ex_cond_op;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [31:0] ex_offs;
  logic [1:0]  ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic [31:0] fact_pc;
  logic [31:0] fact_tpc;
  logic        fact_taken;
  logic        predict_dir_fail;
  logic        predict_add_fail;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk              (clk),
    .rstn             (rstn),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_btype         (ex_btype),
    .ex_cond_op       (ex_cond_op),
    .ex_src1          (ex_src1),
    .ex_src2          (ex_src2),
    .ex_offs          (ex_offs),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_pc       (ex_pred_pc),
    .fact_pc          (fact_pc),
    .fact_tpc         (fact_tpc),
    .fact_taken       (fact_taken),
    .predict_dir_fail (predict_dir_fail),
    .predict_add_fail (predict_add_fail),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .br_cnt           (br_cnt),
    .miss_cnt         (miss_cnt)
  );

  typedef struct {
    logic [1:0]  btype;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] offs;
    logic [1:0]  pt;
    logic [31:0] ppc;
    logic        e_taken;
    logic [31:0] e_tpc;
    logic        e_dir;
    logic        e_add;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid      = 1'b0;
    ex_stall      = 1'b0;
    ex_pc         = 32'd0;
    ex_btype      = 2'b00;
    ex_cond_op    = 4'd0;
    ex_src1       = 32'd0;
    ex_src2       = 32'd0;
    ex_offs       = 32'd0;
    ex_pred_taken = 2'b00;
    ex_pred_pc    = 32'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic drive(input logic [1:0] bt, input logic [3:0] op, input logic [31:0] pc,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] offs,
                       input logic [1:0] pt, input logic [31:0] ppc);
    ex_valid      = 1'b1;
    ex_btype      = bt;
    ex_cond_op    = op;
    ex_pc         = pc;
    ex_src1       = s1;
    ex_src2       = s2;
    ex_offs       = offs;
    ex_pred_taken = pt;
    ex_pred_pc    = ppc;
  endtask

  initial begin
    // btype op pc s1 s2 offs pt ppc | taken tpc dir add redir rpc
    vecs[0]  = '{2'b10, 4'd0, 32'h1c000100, 32'd5, 32'd5, 32'h40, 2'b01, 32'h1c000140,
                 1'b1, 32'h1c000140, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{2'b10, 4'd1, 32'h1c000200, 32'd7, 32'd7, 32'h10, 2'b10, 32'h1c000210,
                 1'b0, 32'h1c000210, 1'b1, 1'b0, 1'b1, 32'h1c000204};
    vecs[2]  = '{2'b11, 4'd8, 32'h1c000280, 32'h1c008000, 32'd0, 32'h8, 2'b11, 32'h1c000300,
                 1'b1, 32'h1c008008, 1'b0, 1'b1, 1'b1, 32'h1c008008};
    vecs[3]  = '{2'b10, 4'd2, 32'h1c000400, 32'hffffffff, 32'd1, 32'hfffffff0, 2'b00, 32'h0,
                 1'b1, 32'h1c0003f0, 1'b1, 1'b0, 1'b1, 32'h1c0003f0};
    vecs[4]  = '{2'b10, 4'd4, 32'h1c000400, 32'hffffffff, 32'd1, 32'hfffffff0, 2'b00, 32'h0,
                 1'b0, 32'h1c0003f0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{2'b10, 4'd3, 32'h1c000400, 32'd5, 32'd5, 32'h10, 2'b01, 32'h1c000410,
                 1'b1, 32'h1c000410, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{2'b10, 4'd5, 32'h1c000400, 32'd1, 32'hffffffff, 32'h10, 2'b00, 32'h0,
                 1'b0, 32'h1c000410, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{2'b00, 4'd6, 32'h1c000500, 32'd0, 32'd0, 32'h20, 2'b10, 32'h1c000520,
                 1'b0, 32'h1c000520, 1'b1, 1'b0, 1'b1, 32'h1c000504};
    vecs[8]  = '{2'b10, 4'd9, 32'h1c000600, 32'd0, 32'd0, 32'h4, 2'b00, 32'h0,
                 1'b0, 32'h1c000604, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{2'b01, 4'd6, 32'hfffffff0, 32'd0, 32'd0, 32'h20, 2'b01, 32'h00000010,
                 1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{2'b01, 4'd7, 32'h1c000700, 32'd0, 32'd0, 32'h100, 2'b01, 32'h1c000900,
                 1'b1, 32'h1c000800, 1'b0, 1'b1, 1'b1, 32'h1c000800};

    rstn = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_fact_pc", fact_pc, 32'h0);
    chk("rst_fact_tpc", fact_tpc, 32'h0);
    chk("rst_fact_taken", {31'd0, fact_taken}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    rstn = 1'b1;

    // Each vector starts from reset so state and counters are known.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(vecs[i].btype, vecs[i].op, vecs[i].pc, vecs[i].s1, vecs[i].s2, vecs[i].offs,
            vecs[i].pt, vecs[i].ppc);
      tick();
      idle_inputs();
      chk($sformatf("v%0d_fact_taken", i), {31'd0, fact_taken}, {31'd0, vecs[i].e_taken});
      chk($sformatf("v%0d_fact_pc", i), fact_pc, vecs[i].pc);
      chk($sformatf("v%0d_fact_tpc", i), fact_tpc, vecs[i].e_tpc);
      chk($sformatf("v%0d_dir_fail", i), {31'd0, predict_dir_fail}, {31'd0, vecs[i].e_dir});
      chk($sformatf("v%0d_add_fail", i), {31'd0, predict_add_fail}, {31'd0, vecs[i].e_add});
      chk($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_redir});
      if (vecs[i].e_redir)
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d_br_cnt", i), br_cnt, (vecs[i].btype != 2'b00) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_miss_cnt", i), miss_cnt, vecs[i].e_redir ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("v%0d_pulse_taken", i), {31'd0, fact_taken}, 32'd0);
      chk($sformatf("v%0d_pulse_redirect", i), {31'd0, redirect_valid}, 32'd0);
      chk($sformatf("v%0d_hold_fact_pc", i), fact_pc, vecs[i].pc);
    end

    // Wrong-path instruction ignored in SHADOW, redirect target accepted, back to RUN.
    do_reset();
    drive(2'b10, 4'd1, 32'h1c000200, 32'd7, 32'd7, 32'h10, 2'b10, 32'h1c000210);
    tick();
    chk("sh_redirect_pc", redirect_pc, 32'h1c000204);
    chk("sh_miss_cnt", miss_cnt, 32'd1);
    drive(2'b10, 4'd0, 32'h1c000208, 32'd1, 32'd1, 32'h40, 2'b01, 32'h1c000248);
    tick();
    chk("sh_ignored_taken", {31'd0, fact_taken}, 32'd0);
    chk("sh_ignored_fact_pc", fact_pc, 32'h1c000200);
    chk("sh_ignored_br_cnt", br_cnt, 32'd1);
    chk("sh_ignored_miss_cnt", miss_cnt, 32'd1);
    drive(2'b10, 4'd0, 32'h1c000204, 32'd1, 32'd1, 32'h40, 2'b01, 32'h1c000244);
    tick();
    chk("sh_target_taken", {31'd0, fact_taken}, 32'd1);
    chk("sh_target_fact_pc", fact_pc, 32'h1c000204);
    chk("sh_target_br_cnt", br_cnt, 32'd2);
    chk("sh_target_redirect", {31'd0, redirect_valid}, 32'd0);
    drive(2'b00, 4'd0, 32'h1c000300, 32'd0, 32'd0, 32'h0, 2'b00, 32'h0);
    tick();
    chk("sh_run_fact_pc", fact_pc, 32'h1c000300);
    chk("sh_run_br_cnt", br_cnt, 32'd2);
    idle_inputs();

    // Stalled taken b: one pulse only, after the stall drops.
    do_reset();
    drive(2'b01, 4'd6, 32'h1c001000, 32'd0, 32'd0, 32'h80, 2'b01, 32'h1c001080);
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_taken", k), {31'd0, fact_taken}, 32'd0);
      chk($sformatf("stall%0d_br_cnt", k), br_cnt, 32'd0);
    end
    ex_stall = 1'b0;
    tick();
    idle_inputs();
    chk("stall_release_taken", {31'd0, fact_taken}, 32'd1);
    chk("stall_release_tpc", fact_tpc, 32'h1c001080);
    chk("stall_release_br_cnt", br_cnt, 32'd1);
    tick();
    chk("stall_after_taken", {31'd0, fact_taken}, 32'd0);
    chk("stall_after_br_cnt", br_cnt, 32'd1);

    // Reset while in SHADOW, with a mispredicting instruction presented.
    do_reset();
    drive(2'b00, 4'd6, 32'h1c000500, 32'd0, 32'd0, 32'h20, 2'b10, 32'h1c000520);
    tick();
    chk("rs_pre_miss_cnt", miss_cnt, 32'd1);
    drive(2'b10, 4'd1, 32'h1c000504, 32'd3, 32'd3, 32'h10, 2'b01, 32'h1c000514);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    idle_inputs();
    chk("rs_fact_pc", fact_pc, 32'h0);
    chk("rs_fact_tpc", fact_tpc, 32'h0);
    chk("rs_fact_taken", {31'd0, fact_taken}, 32'd0);
    chk("rs_dir_fail", {31'd0, predict_dir_fail}, 32'd0);
    chk("rs_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rs_redirect_pc", redirect_pc, 32'h0);
    chk("rs_br_cnt", br_cnt, 32'd0);
    chk("rs_miss_cnt", miss_cnt, 32'd0);
    tick();
    chk("rs_no_redirect", {31'd0, redirect_valid}, 32'd0);
    drive(2'b10, 4'd0, 32'h1c009000, 32'd2, 32'd2, 32'h20, 2'b01, 32'h1c009020);
    tick();
    idle_inputs();
    chk("rs_run_taken", {31'd0, fact_taken}, 32'd1);
    chk("rs_run_fact_pc", fact_pc, 32'h1c009000);
    chk("rs_run_br_cnt", br_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
